// File: rtl/mul_pkg.sv
// Shared widths and operand helpers for the iterative HI/LO multiplier.
package mul_pkg;

    localparam int MUL_W  = 32;
    localparam int PROD_W = 64;
    localparam int CNT_W  = 6;

    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(MUL_W);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(1);

    // Magnitude of a signed operand; 0x80000000 maps to itself, which is the
    // correct unsigned magnitude once treated as 32-bit unsigned.
    function automatic logic [MUL_W-1:0] abs_if_signed(input logic [MUL_W-1:0] x,
                                                       input logic             sign);
        return (sign && x[MUL_W-1]) ? -x : x;
    endfunction

endpackage

// File: rtl/mul.sv
// Iterative 32x32->64 shift-add multiplier (MULT/MULTU), one multiplier bit per cycle.
// Optional early completion once remaining multiplier bits are zero: define MUL_EARLY_TERM_EN.
module mul
    import mul_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             sign,
    input  logic [MUL_W-1:0] multiplicand,
    input  logic [MUL_W-1:0] multiplier,
    output logic             ready,
    output logic [MUL_W-1:0] hi,
    output logic [MUL_W-1:0] lo
);

    logic [CNT_W-1:0]  cnt;
    logic [PROD_W-1:0] acc;
    logic [PROD_W-1:0] mcand;
    logic [MUL_W-1:0]  mplr;
    logic              neg;

    logic [PROD_W-1:0] acc_next;
    logic [PROD_W-1:0] prod_next;
    logic              last_step;

    // Idle is encoded purely by the step counter reaching zero.
    assign ready = (cnt == '0);

    always_comb begin
        acc_next  = mplr[0] ? (acc + mcand) : acc;
        prod_next = neg ? -acc_next : acc_next;
`ifdef MUL_EARLY_TERM_EN
        last_step = (cnt == CNT_LAST) || ((mplr >> 1) == '0);
`else
        last_step = (cnt == CNT_LAST);
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt   <= '0;
            acc   <= '0;
            mcand <= '0;
            mplr  <= '0;
            neg   <= 1'b0;
            hi    <= '0;
            lo    <= '0;
        end else if (ready) begin
            if (start) begin
                cnt   <= CNT_FULL;
                acc   <= '0;
                mcand <= {{MUL_W{1'b0}}, abs_if_signed(multiplicand, sign)};
                mplr  <= abs_if_signed(multiplier, sign);
                neg   <= sign & (multiplicand[MUL_W-1] ^ multiplier[MUL_W-1]);
            end
        end else begin
            acc   <= acc_next;
            mcand <= mcand << 1;
            mplr  <= mplr >> 1;
            // Forcing zero on the last step also covers early completion.
            cnt   <= last_step ? '0 : (cnt - CNT_LAST);
            if (last_step) begin
                {hi, lo} <= prod_next;
            end
        end
    end

endmodule

// File: tb/tb_mul.sv
// Scoreboard bench for mul: expected products/latencies queued at accept, checked on ready rise.
module tb_mul;

    logic        clk;
    logic        reset;
    logic        start;
    logic        sign;
    logic [31:0] multiplicand;
    logic [31:0] multiplier;
    logic        ready;
    logic [31:0] hi;
    logic [31:0] lo;

    mul dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .sign         (sign),
        .multiplicand (multiplicand),
        .multiplier   (multiplier),
        .ready        (ready),
        .hi           (hi),
        .lo           (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] prod;
        int          lat;
    } exp_t;

    exp_t        exp_q[$];
    int          n_checks = 0;
    int          n_errors = 0;
    logic        mon_en   = 1'b0;
    logic [63:0] last_prod = '0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%016h expected 0x%016h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] exp_prod(input logic [31:0] a, input logic [31:0] b,
                                             input logic s);
        logic signed [63:0] sa;
        logic signed [63:0] sb;
        if (s) begin
            sa = {{32{a[31]}}, a};
            sb = {{32{b[31]}}, b};
            return 64'(sa * sb);
        end
        return {32'd0, a} * {32'd0, b};
    endfunction

    function automatic int exp_lat(input logic [31:0] b, input logic s);
        logic [31:0] m;
        int          early;
        m     = (s && b[31]) ? (~b + 32'd1) : b;
        early = 1;
        for (int i = 0; i < 32; i++) begin
            if (m[i]) early = i + 1;
        end
`ifdef MUL_EARLY_TERM_EN
        return early;
`else
        return (early > 0) ? 32 : 32;
`endif
    endfunction

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic s);
        exp_t e;
        int   n;
        n = 0;
        while (!ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!ready) check_eq("ready_timeout", {63'd0, ready}, 64'd1);
        start        = 1'b1;
        multiplicand = a;
        multiplier   = b;
        sign         = s;
        e.prod = exp_prod(a, b, s);
        e.lat  = exp_lat(b, s);
        exp_q.push_back(e);
        @(negedge clk);
        start = 1'b0;
    endtask

    // Monitor: counts busy cycles, checks hold while busy and result on completion.
    initial begin
        logic prev_ready;
        int   busy;
        exp_t e;
        prev_ready = 1'b1;
        busy       = 0;
        forever begin
            @(posedge clk);
            #1;
            if (!mon_en || reset) begin
                busy       = 0;
                prev_ready = 1'b1;
            end else if (!ready) begin
                busy++;
                check_eq("hold_busy", {hi, lo}, last_prod);
                prev_ready = 1'b0;
            end else begin
                if (!prev_ready) begin
                    if (exp_q.size() == 0) begin
                        check_eq("spurious_done", 64'd1, 64'd0);
                    end else begin
                        e = exp_q.pop_front();
                        check_eq("product", {hi, lo}, e.prod);
                        check_eq("latency", 64'(busy), 64'(e.lat));
                        last_prod = e.prod;
                    end
                end
                busy       = 0;
                prev_ready = 1'b1;
            end
        end
    end

    initial begin
        int n;
        reset        = 1'b1;
        start        = 1'b0;
        sign         = 1'b0;
        multiplicand = '0;
        multiplier   = '0;
        repeat (2) @(negedge clk);
        check_eq("rst_ready", {63'd0, ready}, 64'd1);
        check_eq("rst_hilo", {hi, lo}, 64'd0);
        reset  = 1'b0;
        mon_en = 1'b1;
        @(negedge clk);

        run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        run_op(32'hFFFF_FFFF, 32'h0000_0001, 1'b1);
        run_op(32'hFFFF_FFFF, 32'h0000_0001, 1'b0);
        run_op(32'h8000_0000, 32'h8000_0000, 1'b1);
        run_op(32'h8000_0000, 32'h0000_0001, 1'b1);

        // Operand stability: inputs churn while busy, only one op may run.
        run_op(32'd7, 32'd6, 1'b0);
        n = 0;
        while (!ready && n < 40) begin
            start        = ~start;
            multiplicand = $urandom;
            multiplier   = $urandom;
            sign         = ~sign;
            @(negedge clk);
            n++;
        end
        start = 1'b0;
        check_eq("stable_ready", {63'd0, ready}, 64'd1);
        @(negedge clk);
        @(negedge clk);
        check_eq("stable_idle", {63'd0, ready}, 64'd1);
        check_eq("stable_q", 64'(exp_q.size()), 64'd0);

        // Reset mid-operation discards the in-flight product.
        mon_en       = 1'b0;
        start        = 1'b1;
        multiplicand = 32'd3;
        multiplier   = 32'd5;
        sign         = 1'b0;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        check_eq("rst_mid_busy", {63'd0, ready}, 64'd0);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check_eq("rst_mid_ready", {63'd0, ready}, 64'd1);
        check_eq("rst_mid_hilo", {hi, lo}, 64'd0);
        last_prod = '0;
        @(negedge clk);
        mon_en = 1'b1;
        @(negedge clk);
        run_op(32'd3, 32'd5, 1'b0);

        run_op(32'h1234_5678, 32'h0000_0000, 1'b0);
        run_op(32'h1234_5678, 32'h0000_0100, 1'b0);
        run_op(32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b1);
        for (int i = 0; i < 4; i++) begin
            run_op($urandom, $urandom, 1'($urandom_range(0, 1)));
        end

        n = 0;
        while ((exp_q.size() != 0 || !ready) && n < 200) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        check_eq("drain", 64'(exp_q.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
